lsu_mem_arbiter: RTL
====================

Name: lsu_mem_arbiter

Overview:
- Sits directly downstream of the per-thread LSUs in a core. Consumes their LDR/STR requests and funnels them onto one shared data-memory channel.
- Uses round-robin arbitration. Runs one transaction at a time, relays the memory response back to the granted LSU, and holds the ready/valid handshake until that LSU releases its request.

Parameters:
ADDR_BITS, 8, data-memory address width
DATA_BITS, 16, data word width (Q1.15)
NUM_CONSUMERS, 4, number of LSUs arbitrated (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  per-LSU read address; LSU i occupies bits [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  per-LSU read completion
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  per-LSU returned data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  per-LSU write address
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  per-LSU write data
consumer_write_ready  out  NUM_CONSUMERS  per-LSU write completion
mem_read_valid  out  1  memory read request
mem_read_address  out  ADDR_BITS  memory read address
mem_read_ready  in  1  memory read data valid
mem_read_data  in  DATA_BITS  memory read data
mem_write_valid  out  1  memory write request
mem_write_address  out  ADDR_BITS  memory write address
mem_write_data  out  DATA_BITS  memory write data
mem_write_ready  in  1  memory write accepted

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, rr_ptr=0, grant index 0.
- Registers: every output is registered; there are no combinational paths from inputs to outputs.
- State machine states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE: scan i = rr_ptr, rr_ptr+1, ... (mod NUM_CONSUMERS). The first i with read_valid or write_valid wins.
  - If the winner has both valids high, read wins; its write is served on a later grant.
  - On this edge latch grant=i.
  - For a read: drive mem_read_valid=1 and mem_read_address=addr_i; go to READ_WAITING.
  - For a write: drive mem_write_valid=1, mem_write_address and mem_write_data from LSU i; go to WRITE_WAITING.
  - If no request is pending, stay in IDLE.
- READ_WAITING: mem_read_valid and address are held stable until mem_read_ready=1 is sampled. On that edge:
  - mem_read_valid <= 0;
  - consumer_read_data[grant] <= mem_read_data;
  - consumer_read_ready[grant] <= 1;
  - go to READ_RELAYING.
- WRITE_WAITING: the same handshake using mem_write_ready. Set consumer_write_ready[grant] <= 1 and go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING: hold ready (and read data) until the granted LSU's corresponding valid is sampled 0. On that edge:
  - ready[grant] <= 0;
  - rr_ptr <= (grant+1) mod NUM_CONSUMERS;
  - go to IDLE.
- Latency:
  - Request sampled in IDLE at edge N gives mem valid high after edge N.
  - Memory ready sampled at edge M gives consumer ready high after edge M.
  - Minimum turnaround, valid seen to consumer ready, is 2 cycles with zero-wait memory.
  - A new grant is issued no earlier than 1 cycle after the consumer drops valid.
- Only one of mem_read_valid and mem_write_valid is ever high at a time.
- At most one consumer ready bit is high at any time, and only for grant.
- consumer_read_data of non-granted LSUs holds its last value.
- Fairness: a continuously requesting LSU waits at most NUM_CONSUMERS-1 other transactions.
- Request-change rules:
  - Requests from non-granted LSUs are ignored until IDLE.
  - A granted LSU dropping valid while in a WAITING state does not abort; the memory transaction completes and ready is pulsed for 1 cycle, because RELAYING sees valid=0 immediately.
  - Inputs of the granted LSU are not re-sampled after grant.
- Reset mid-transaction: the in-flight transaction is abandoned and all valids/readies drop to 0 immediately. No retry is performed.
- NUM_CONSUMERS=1: rr_ptr is always 0; behaviour is otherwise identical.

Test Plan:
- Single read (LSU2 read addr 0x3A, memory returns 0x4000 with 3-cycle latency) -> mem_read_address=0x3A; consumer_read_data[2]=0x4000 and consumer_read_ready[2]=1 one cycle after mem_read_ready; after LSU2 drops valid, ready clears and rr_ptr=3.
- Single write (LSU0 write addr 0x10, data 0x8001, zero-wait memory) -> mem_write_address=0x10, mem_write_data=0x8001 held until ready; consumer_write_ready[0] rises 2 cycles after request; no mem read activity.
- All 4 LSUs issue reads at once from reset, each held until served -> grant order 0,1,2,3; mem_read_valid never overlaps; each LSU receives its own address's data.
- Round-robin wrap: rr_ptr=3, LSU0 and LSU3 requesting -> LSU3 is served first, then LSU0.
- Mixed traffic: LSU1 write and LSU2 read pending, rr_ptr=1 -> write is served before read; mem_read_valid and mem_write_valid are never high together.
- Async reset asserted mid-cycle during READ_WAITING -> all outputs are 0 before the next clk edge; after release a new request is granted from rr_ptr=0.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// Bus bundles for the LSU arbiter: the per-LSU request/response side and the
// shared data-memory channel. Master drives requests, slave answers them.
interface lsu_bus_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready
  );
  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );
  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter funnelling per-LSU load/store requests onto one data-memory
// channel, one transaction at a time, with fully registered outputs.
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic      clk,
  input  logic      reset,
  lsu_bus_if.slave  lsu,
  mem_bus_if.master mem
);
  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CONSUMERS);

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                   grant_q, grant_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
  logic                               mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

  logic [NUM_CONSUMERS-1:0] rv, wv;
  logic                     found, pick_rd;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W:0]           cand, rr_next;

  assign rv = lsu.consumer_read_valid;
  assign wv = lsu.consumer_write_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      rr_ptr_q            <= '0;
      grant_q             <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      read_data_q         <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_q             <= grant_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      write_ready_q       <= write_ready_d;
      read_data_q         <= read_data_d;
    end
  end

  // Scan from rr_ptr with wraparound; a read beats a write from the same LSU.
  always_comb begin
    found    = 1'b0;
    pick_rd  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= NC) cand = cand - NC;
      if (!found && (rv[cand[IDX_W-1:0]] || wv[cand[IDX_W-1:0]])) begin
        found    = 1'b1;
        pick_idx = cand[IDX_W-1:0];
        pick_rd  = rv[cand[IDX_W-1:0]];
      end
    end
    rr_next = {1'b0, grant_q} + 1'b1;
    if (rr_next >= NC) rr_next = '0;

    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: if (found) begin
        grant_d = pick_idx;
        state_d = pick_rd ? READ_WAITING : WRITE_WAITING;
      end
      READ_WAITING:  if (mem.mem_read_ready)  state_d = READ_RELAYING;
      WRITE_WAITING: if (mem.mem_write_ready) state_d = WRITE_RELAYING;
      READ_RELAYING: if (!rv[grant_q]) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next[IDX_W-1:0];
      end
      WRITE_RELAYING: if (!wv[grant_q]) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next[IDX_W-1:0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    write_ready_d       = write_ready_q;
    read_data_d         = read_data_q;
    unique case (state_q)
      IDLE: if (found) begin
        if (pick_rd) begin
          mem_read_valid_d   = 1'b1;
          mem_read_address_d = lsu.consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
        end else begin
          mem_write_valid_d   = 1'b1;
          mem_write_address_d = lsu.consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
          mem_write_data_d    = lsu.consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
        end
      end
      READ_WAITING: if (mem.mem_read_ready) begin
        mem_read_valid_d                             = 1'b0;
        read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem.mem_read_data;
        read_ready_d[grant_q]                        = 1'b1;
      end
      WRITE_WAITING: if (mem.mem_write_ready) begin
        mem_write_valid_d      = 1'b0;
        write_ready_d[grant_q] = 1'b1;
      end
      READ_RELAYING:  if (!rv[grant_q]) read_ready_d = '0;
      WRITE_RELAYING: if (!wv[grant_q]) write_ready_d = '0;
      default: ;
    endcase
  end

  assign mem.mem_read_valid          = mem_read_valid_q;
  assign mem.mem_read_address        = mem_read_address_q;
  assign mem.mem_write_valid         = mem_write_valid_q;
  assign mem.mem_write_address       = mem_write_address_q;
  assign mem.mem_write_data          = mem_write_data_q;
  assign lsu.consumer_read_ready     = read_ready_q;
  assign lsu.consumer_write_ready    = write_ready_q;
  assign lsu.consumer_read_data      = read_data_q;
endmodule
